// File: rtl/mavg_seq.sv
// mavg_seq: sample sequencer in front of the mavg moving-average core.
//
// Samples are buffered in a small FIFO and streamed into the core one per
// clock in bursts. The core is held in reset between bursts so every burst
// starts from a cleared window. A tag pipeline that runs in parallel with the
// core marks which core outputs come from a full window of real samples.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready/
//   s_data[3:0]         sample input handshake
//   core_x[3:0]         registered sample to the core
//   core_reset          registered reset to the core
//   core_y[3:0]         core average output
//   m_valid, m_data     registered result strobe and data (no backpressure)
//   busy                sequencer is not idle
//   underrun            one-cycle pulse when a burst ends
//
// Handshake: a sample transfers on every rising edge where s_valid and
// s_ready are both high. s_ready depends only on the registered FIFO count,
// never on s_valid or on a pop happening in the same cycle. The result side
// has no ready: m_valid is a one-cycle strobe and an unconsumed result is lost.
module mavg_seq #(
    parameter int DEPTH       = 4,  // core averaging window length
    parameter int LAT         = 1,  // core latency core_x -> core_y, >= 1
    parameter int FIFO_DEPTH  = 4,  // input buffer entries
    parameter int START_LEVEL = 2,  // occupancy that starts a burst
    parameter int FLUSH_CYC   = 2   // cycles core_reset is held after a burst, >= 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [3:0] s_data,
    output logic [3:0] core_x,
    output logic       core_reset,
    input  logic [3:0] core_y,
    output logic       m_valid,
    output logic [3:0] m_data,
    output logic       busy,
    output logic       underrun
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int SW   = $clog2(DEPTH + 1);
    localparam int TMAX = (LAT > FLUSH_CYC) ? LAT : FLUSH_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [3:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   samp_cnt_q, samp_cnt_d;
    logic [SW-1:0]   samp_inc;
    logic [TW-1:0]   timer_q, timer_d;
    logic [LAT:0]    tag_q, tag_d;
    logic [3:0]      core_x_q, core_x_d;
    logic            core_reset_q, core_reset_d;
    logic            m_valid_q, m_valid_d;
    logic [3:0]      m_data_q, m_data_d;
    logic            underrun_q, underrun_d;
    logic            push, pop, tag_in;

    assign s_ready    = (count_q < CW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign busy       = (state_q != S_IDLE);
    assign core_x     = core_x_q;
    assign core_reset = core_reset_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign underrun   = underrun_q;

    // Sequencer: decides pops and what the core sees next cycle.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        samp_cnt_d   = samp_cnt_q;
        core_x_d     = 4'd0;
        core_reset_d = 1'b0;
        underrun_d   = 1'b0;
        tag_in       = 1'b0;
        pop          = 1'b0;
        // Saturating sample count, so tags stay high for the rest of a burst.
        samp_inc     = (samp_cnt_q == SW'(DEPTH)) ? samp_cnt_q : samp_cnt_q + SW'(1);

        case (state_q)
            S_IDLE: begin
                core_reset_d = 1'b1;
                if (count_q >= CW'(START_LEVEL)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    core_x_d   = mem_q[rd_ptr_q];
                    samp_cnt_d = samp_inc;
                    tag_in     = (samp_inc == SW'(DEPTH));
                end else begin
                    // Empty at start of cycle ends the burst even if a push
                    // lands this cycle.
                    underrun_d = 1'b1;
                    state_d    = S_DRAIN;
                    timer_d    = TW'(LAT - 1);
                end
            end
            S_DRAIN: begin
                // Let in-flight samples leave the core; the last drain cycle
                // already loads core_reset so it rises LAT cycles after
                // the underrun pulse.
                if (timer_q == '0) begin
                    state_d      = S_FLUSH;
                    timer_d      = TW'(FLUSH_CYC - 1);
                    samp_cnt_d   = '0;
                    core_reset_d = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_FLUSH: begin
                core_reset_d = 1'b1;
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Input FIFO.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Tag pipeline: stage 0 lines up with core_x, stage LAT with core_y.
    always_comb begin
        tag_d     = {tag_q[LAT-1:0], tag_in};
        m_valid_d = tag_q[LAT];
        m_data_d  = core_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'd0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            samp_cnt_q   <= '0;
            timer_q      <= '0;
            tag_q        <= '0;
            core_x_q     <= 4'd0;
            core_reset_q <= 1'b1;
            m_valid_q    <= 1'b0;
            m_data_q     <= 4'd0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            samp_cnt_q   <= samp_cnt_d;
            timer_q      <= timer_d;
            tag_q        <= tag_d;
            core_x_q     <= core_x_d;
            core_reset_q <= core_reset_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_mavg_seq.sv
// tb_mavg_seq: self-checking bench for mavg_seq with a behavioural mavg core.
//
// Each step: at the falling edge the DUT outputs are compared against
// expectations scheduled earlier by the reference model, then new inputs are
// driven and the model advances one cycle. The model works on a sample queue
// and a burst history and schedules future outputs by the documented latencies.
module tb_mavg_seq;

  localparam int DEPTH       = 4;
  localparam int LAT         = 1;
  localparam int FIFO_DEPTH  = 4;
  localparam int START_LEVEL = 2;
  localparam int FLUSH_CYC   = 2;
  localparam int MAXC        = 4096;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_GAP  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic [3:0] core_x;
  logic       core_reset;
  logic [3:0] core_y;
  logic       m_valid;
  logic [3:0] m_data;
  logic       busy;
  logic       underrun;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mavg_seq dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .core_x     (core_x),
    .core_reset (core_reset),
    .core_y     (core_y),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .busy       (busy),
    .underrun   (underrun)
  );

  // Behavioural core: registered floor(sum of last 4 samples / 4), sync clear.
  logic [3:0] win [3];
  initial begin
    for (int i = 0; i < 3; i++) win[i] = 4'd0;
    core_y = 4'd0;
  end
  always @(posedge clk) begin
    if (core_reset) begin
      win[0] <= 4'd0;
      win[1] <= 4'd0;
      win[2] <= 4'd0;
      core_y <= 4'd0;
    end else begin
      win[0] <= core_x;
      win[1] <= win[0];
      win[2] <= win[1];
      core_y <= 4'((6'(core_x) + 6'(win[0]) + 6'(win[1]) + 6'(win[2])) >> 2);
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int checks;
  int failures;
  int j;

  bit         exp_mv [MAXC];
  logic [3:0] exp_md [MAXC];
  bit         exp_ur [MAXC];
  logic [3:0] exp_cx [MAXC];
  bit         exp_cr [MAXC];

  logic [3:0] exp_q [$];   // samples accepted and not yet popped
  logic [3:0] hist [$];    // last DEPTH samples popped in the current burst
  int         mode;
  int         burst_len;
  int         rise_at;
  int         idle_at;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, j, got, exp);
    end
  endfunction

  function automatic logic [3:0] window_avg();
    int sum;
    sum = 0;
    foreach (hist[i]) sum += int'(hist[i]);
    return 4'(sum / DEPTH);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    mode      = M_IDLE;
    burst_len = 0;
    rise_at   = 0;
    idle_at   = 0;
    for (int k = j; k < MAXC; k++) begin
      exp_mv[k] = 1'b0;
      exp_md[k] = 4'd0;
      exp_ur[k] = 1'b0;
      exp_cx[k] = 4'd0;
      exp_cr[k] = 1'b1;
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input logic v, input logic [3:0] d,
                      output logic o_mv, output logic [3:0] o_md,
                      output logic o_ur, output logic o_sr, output logic o_busy);
    logic [3:0] h;
    logic       acc;
    @(negedge clk);
    if (j + LAT + 3 >= MAXC) begin
      $display("FAIL step_budget step=%0d limit=%0d", j, MAXC);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "step budget exhausted");
    end
    o_mv = m_valid; o_md = m_data; o_ur = underrun; o_sr = s_ready; o_busy = busy;
    if (mode == M_GAP && j == idle_at) mode = M_IDLE;
    chk("s_ready", s_ready, exp_q.size() < FIFO_DEPTH);
    chk("busy", busy, mode != M_IDLE);
    chk("core_x", core_x, exp_cx[j]);
    chk("core_reset", core_reset, exp_cr[j]);
    chk("m_valid", m_valid, exp_mv[j]);
    if (exp_mv[j]) chk("m_data", m_data, exp_md[j]);
    chk("underrun", underrun, exp_ur[j]);

    s_valid = v;
    s_data  = d;
    acc = v && (exp_q.size() < FIFO_DEPTH);
    case (mode)
      M_IDLE: begin
        exp_cx[j+1] = 4'd0;
        exp_cr[j+1] = 1'b1;
        if (exp_q.size() >= START_LEVEL) mode = M_RUN;
      end
      M_RUN: begin
        if (exp_q.size() > 0) begin
          h = exp_q.pop_front();
          hist.push_back(h);
          if (hist.size() > DEPTH) void'(hist.pop_front());
          burst_len++;
          exp_cx[j+1] = h;
          exp_cr[j+1] = 1'b0;
          if (burst_len >= DEPTH) begin
            exp_mv[j+2+LAT] = 1'b1;
            exp_md[j+2+LAT] = window_avg();
          end
        end else begin
          exp_ur[j+1] = 1'b1;
          exp_cx[j+1] = 4'd0;
          exp_cr[j+1] = 1'b0;
          rise_at   = j + 1 + LAT;
          idle_at   = j + 1 + LAT + FLUSH_CYC;
          mode      = M_GAP;
          burst_len = 0;
          hist.delete();
        end
      end
      default: begin
        exp_cx[j+1] = 4'd0;
        exp_cr[j+1] = (j + 1 >= rise_at);
      end
    endcase
    if (acc) exp_q.push_back(d);
    j++;
  endtask

  task automatic idle_steps(input int n);
    logic a, c, e, f;
    logic [3:0] b;
    for (int k = 0; k < n; k++) step(1'b0, 4'd0, a, b, c, e, f);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       mv;
    logic [3:0] md;
    logic       ur;
    logic       busy;
  } vec_t;

  vec_t       tbl [16];
  logic       o_mv, o_ur, o_sr, o_busy;
  logic [3:0] o_md;
  int         n_mv, n_ur, n_srlow, n_bad;
  logic [3:0] first_md;
  logic       got_first;
  int         prob;

  initial begin
    // Ramp 0..7 from idle: decision at step 2, pops at steps 3..10,
    // strobes 1..5 at steps 9..13, underrun pulse at 12, idle at 15.
    tbl = '{
      '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0},
      '{1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0},
      '{1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0},
      '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1},
      '{1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 1'b1},
      '{1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b1},
      '{1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 1'b1},
      '{1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1},
      '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1},
      '{1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b1},
      '{1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b1},
      '{1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b1},
      '{1'b0, 4'd0, 1'b1, 4'd4, 1'b1, 1'b1},
      '{1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b1},
      '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1},
      '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0}
    };

    checks   = 0;
    failures = 0;
    j        = 0;
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_data   = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Async reset in the middle of a burst.
    for (int k = 0; k < 5; k++) step(1'b1, 4'd5, o_mv, o_md, o_ur, o_sr, o_busy);
    chk("pre_reset_core_x", core_x, 4'd5);
    #2;
    reset   = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_core_x", core_x, 4'd0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_m_data", m_data, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b0, 4'd0, o_mv, o_md, o_ur, o_sr, o_busy);
    chk("post_rst_s_ready", o_sr, 1'b1);
    chk("post_rst_busy", o_busy, 1'b0);

    // Ramp burst from the vector table.
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].v, tbl[k].d, o_mv, o_md, o_ur, o_sr, o_busy);
      chk("tbl_m_valid", o_mv, tbl[k].mv);
      if (tbl[k].mv) chk("tbl_m_data", o_md, tbl[k].md);
      chk("tbl_underrun", o_ur, tbl[k].ur);
      chk("tbl_busy", o_busy, tbl[k].busy);
    end
    idle_steps(2);

    // Eight samples of value 8: five strobes, all 8, one underrun.
    n_mv = 0; n_ur = 0; n_bad = 0;
    for (int k = 0; k < 18; k++) begin
      step(k < 8, 4'd8, o_mv, o_md, o_ur, o_sr, o_busy);
      if (o_mv) begin
        n_mv++;
        if (o_md !== 4'd8) n_bad++;
      end
      if (o_ur) n_ur++;
    end
    chk("const8_strobes", n_mv, 5);
    chk("const8_bad_data", n_bad, 0);
    chk("const8_underruns", n_ur, 1);
    chk("const8_idle_busy", o_busy, 1'b0);

    // Short burst of two samples: no strobes, one underrun, FIFO empty after.
    n_mv = 0; n_ur = 0;
    for (int k = 0; k < 12; k++) begin
      step(k < 2, 4'd9, o_mv, o_md, o_ur, o_sr, o_busy);
      if (o_mv) n_mv++;
      if (o_ur) n_ur++;
    end
    chk("short_strobes", n_mv, 0);
    chk("short_underruns", n_ur, 1);
    chk("short_s_ready", o_sr, 1'b1);

    // Forced underrun, then s_valid held high through the gap: FIFO fills to
    // 4, s_ready low for the full cycle and the following pop cycle, then ten
    // accepted samples give seven strobes, first one 15.
    n_mv = 0; n_ur = 0; n_srlow = 0; got_first = 1'b0; first_md = 4'd0;
    for (int k = 0; k < 31; k++) begin
      step((k < 2) || (k >= 5 && k <= 16), 4'd15, o_mv, o_md, o_ur, o_sr, o_busy);
      if (o_mv) begin
        n_mv++;
        if (!got_first) begin
          first_md  = o_md;
          got_first = 1'b1;
        end
      end
      if (o_ur) n_ur++;
      if (!o_sr) n_srlow++;
    end
    chk("fill_strobes", n_mv, 7);
    chk("fill_first_data", first_md, 4'd15);
    chk("fill_underruns", n_ur, 2);
    chk("fill_s_ready_low", n_srlow, 2);

    // Randomized traffic with varying offered load.
    for (int b = 0; b < 30; b++) begin
      prob = int'($urandom_range(5, 100));
      for (int k = 0; k < 50; k++) begin
        step(int'($urandom_range(0, 99)) < prob, 4'($urandom_range(0, 15)),
             o_mv, o_md, o_ur, o_sr, o_busy);
      end
    end
    idle_steps(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mavg_seq.md
# mavg_seq

Sample sequencer for the moving-average core. Buffers 4-bit samples arriving over a valid/ready handshake and streams them into the core at one sample per clock in bursts. Sequences the core's reset so each burst starts from a cleared window, and tags core outputs as valid only when the averaging window holds real samples. Sits between the input pads and the `mavg` core; the core's `x`, `y` and `reset` connect to this block's `core_*` ports.

## Interface
- `DEPTH`, 4: core averaging window length in samples.
- `LAT`, 1: core latency in cycles from `core_x` to the corresponding `core_y`.
- `FIFO_DEPTH`, 4: input buffer entries.
- `START_LEVEL`, 2: buffer occupancy that starts a burst. Legal range is 1..`FIFO_DEPTH`.
- `FLUSH_CYC`, 2: cycles `core_reset` is held after a burst before returning to IDLE.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `s_valid` input 1: sample offered.
- `s_ready` output 1: buffer can accept; equals `count < FIFO_DEPTH`.
- `s_data` input 4: unsigned sample.
- `core_x` output 4: registered sample to core.
- `core_reset` output 1: registered reset to core.
- `core_y` input 4: core average output.
- `m_valid` output 1: registered result valid, one-cycle strobe per result.
- `m_data` output 4: registered copy of `core_y`.
- `busy` output 1: state is not IDLE.
- `underrun` output 1: one-cycle pulse when a burst ends.

## Operation
Input buffer:
- FIFO of `FIFO_DEPTH` x 4 bits.
- A push occurs when `s_valid && s_ready`.
- Push and pop may occur in the same cycle; `count` is then unchanged.
- `s_ready` is derived from the registered `count` only, so it is low when the FIFO is full even if a pop happens that cycle.

States:
- IDLE
  - `core_reset` is 1 and `core_x` is 0.
  - Transitions to RUN when `count >= START_LEVEL`. Comparison uses the start-of-cycle `count`.
- RUN, with `count > 0`
  - Pop the head.
  - `core_x` takes the head value and `core_reset` takes 0.
  - `samp_cnt` increments, saturating at `DEPTH`.
  - Launch a tag that is 1 iff the incremented `samp_cnt` equals `DEPTH`.
- RUN, with `count == 0`
  - An underrun. This holds even if a push happens in the same cycle.
  - Go to DRAIN and pulse `underrun`.
  - `core_x` takes 0, `core_reset` stays 0, and a 0 tag is launched.
- DRAIN
  - Lasts `LAT` cycles. `core_reset` is 0, `core_x` is 0, and 0 tags are launched.
  - This lets in-flight samples emerge from the core before it is cleared.
  - Then go to FLUSH.
- FLUSH
  - `core_reset` is 1 for `FLUSH_CYC` cycles; `samp_cnt` is cleared on entry.
  - Then go to IDLE.

Additional rules:
- Pushes are accepted in every state.
- Tag pipeline: `LAT`+1 stages. `m_valid` takes the last stage, and `m_data` takes `core_y` every cycle.
- No backpressure on the output side. A result not consumed on its `m_valid` cycle is lost.
- Async `reset` clears the following, immediately:
  - FIFO, with `count` = 0.
  - State to IDLE.
  - `samp_cnt` and all tags to 0.
  - `core_x`, `m_data`, `m_valid`, `underrun` to 0.
  - `core_reset` to 1.
- After reset deasserts, `s_ready` = 1 and `busy` = 0.

## Timing
- Pop in cycle t:
  - Sample is on `core_x` in cycle t+1.
  - Matching `core_y` in cycle t+1+`LAT`.
  - `m_valid`/`m_data` in cycle t+2+`LAT`, which is t+3 at defaults.
- IDLE-to-RUN decision in cycle t; first pop in cycle t+1.
- Underrun detected in cycle t:
  - `underrun` is high in cycle t+1.
  - `core_reset` rises in cycle t+1+`LAT`.
  - State is IDLE in cycle t+1+`LAT`+`FLUSH_CYC`.
- First valid result of a burst corresponds to its `DEPTH`-th popped sample. A burst shorter than `DEPTH` samples produces no `m_valid`.
- Exactly one `m_valid` per popped sample from the `DEPTH`-th onward. Strobes are consecutive while RUN pops every cycle.

## Test plan
Bench conditions: default parameters; core model is a registered floor(sum of last 4 samples / 4) with synchronous clear on `core_reset`.

1. Assert async reset mid-cycle while in RUN -> `m_valid`, `core_x`, `underrun` = 0 and `core_reset` = 1 immediately; after release, `s_ready` = 1 and `busy` = 0.
2. Push 8 in each of 8 consecutive cycles, then stop -> exactly 5 `m_valid` strobes, all `m_data` = 8, then one `underrun` pulse. `core_reset` is high 1 cycle later for 2 cycles, then `busy` = 0.
3. Push ramp 0,1,2,3,4,5,6,7 back-to-back -> `m_data` sequence 1,2,3,4,5 on consecutive `m_valid` cycles, first strobe 3 cycles after the pop of sample 3.
4. Push only 2 samples -> RUN pops both, then underrun; zero `m_valid` strobes and FIFO empty.
5. Hold `s_valid` high continuously with value 15, FIFO starting empty, through a forced underrun gap -> FIFO fills to 4 during DRAIN/FLUSH/IDLE, `s_ready` = 0 while `count` = 4, no sample lost or duplicated, and the next burst's first `m_data` = 15.
6. Push and pop in the same cycle at `count` = 3 -> `count` stays 3 and `s_ready` stays 1; at `count` = 4 with a pop, `s_ready` remains 0 that cycle.
